// File: rtl/toggle_event_decoder.sv
// Receive side of a T flip-flop toggle link: synchronises the toggle wire and
// turns each level change into an event pulse, a wrapping count and a pending queue.
module toggle_event_decoder #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_WIDTH   = 8,
    parameter int unsigned PEND_WIDTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tog_in,
    input  logic                  evt_ready,
    input  logic                  clr_ovf,
    output logic                  evt_pulse,
    output logic [CNT_WIDTH-1:0]  evt_count,
    output logic                  evt_valid,
    output logic [PEND_WIDTH-1:0] pend_count,
    output logic                  overflow
);

    localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_tog_prev;

    logic                   w_sync_out;
    logic                   w_edge_det;
    logic                   w_handshake;
    logic                   w_drop;
    logic [PEND_WIDTH-1:0]  w_pend_nxt;
    logic                   w_ovf_nxt;

    assign w_sync_out  = r_sync[SYNC_STAGES-1];
    assign w_edge_det  = w_sync_out ^ r_tog_prev;
    assign evt_valid   = (pend_count != '0);
    assign w_handshake = evt_valid & evt_ready;

    // Pending-count update; an event arriving at the ceiling is dropped only
    // when no handshake frees a slot on the same edge.
    always_comb begin
        w_pend_nxt = pend_count;
        w_drop     = 1'b0;
        case ({w_edge_det, w_handshake})
            2'b10: begin
                if (pend_count == PEND_MAX) begin
                    w_drop = 1'b1;
                end else begin
                    w_pend_nxt = pend_count + PEND_WIDTH'(1);
                end
            end
            2'b01:   w_pend_nxt = pend_count - PEND_WIDTH'(1);
            default: w_pend_nxt = pend_count;
        endcase
        // A drop on the same edge as a clear keeps the flag set.
        w_ovf_nxt = w_drop | (overflow & ~clr_ovf);
    end

    // Synchroniser and previous-level register, falling-edge clocked.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync     <= '0;
            r_tog_prev <= 1'b0;
        end else begin
            r_sync     <= {r_sync[SYNC_STAGES-2:0], tog_in};
            r_tog_prev <= w_sync_out;
        end
    end

    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            evt_pulse  <= 1'b0;
            evt_count  <= '0;
            pend_count <= '0;
            overflow   <= 1'b0;
        end else begin
            evt_pulse  <= w_edge_det;
            pend_count <= w_pend_nxt;
            overflow   <= w_ovf_nxt;
            if (w_edge_det) begin
                evt_count <= evt_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Directed bench for toggle_event_decoder with default parameters
// (SYNC_STAGES=2, CNT_WIDTH=8, PEND_WIDTH=4).
module tb_toggle_event_decoder;

    logic       clk;
    logic       rst_n;
    logic       tog_in;
    logic       evt_ready;
    logic       clr_ovf;
    logic       evt_pulse;
    logic [7:0] evt_count;
    logic       evt_valid;
    logic [3:0] pend_count;
    logic       overflow;

    int n_pass  = 0;
    int n_total = 0;
    logic pend_hi;

    toggle_event_decoder #(
        .SYNC_STAGES(2),
        .CNT_WIDTH  (8),
        .PEND_WIDTH (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tog_in    (tog_in),
        .evt_ready (evt_ready),
        .clr_ovf   (clr_ovf),
        .evt_pulse (evt_pulse),
        .evt_count (evt_count),
        .evt_valid (evt_valid),
        .pend_count(pend_count),
        .overflow  (overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance past one active (falling) edge and settle.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Flip the line and wait until the edge where the pulse should be high.
    task automatic do_toggle();
        tog_in = ~tog_in;
        step();
        step();
        step();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic check_all(input string tag, input logic p, input logic [7:0] c,
                             input logic v, input logic [3:0] pc, input logic o);
        check({tag, ".pulse"}, 32'(evt_pulse), 32'(p));
        check({tag, ".count"}, 32'(evt_count), 32'(c));
        check({tag, ".valid"}, 32'(evt_valid), 32'(v));
        check({tag, ".pend"},  32'(pend_count), 32'(pc));
        check({tag, ".ovf"},   32'(overflow), 32'(o));
    endtask

    initial begin
        rst_n     = 1'b0;
        tog_in    = 1'b0;
        evt_ready = 1'b0;
        clr_ovf   = 1'b0;
        #2;
        check_all("reset", 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();
        step();
        check_all("idle", 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);

        // 1: single rising toggle, exact pulse latency and width
        tog_in = 1'b1;
        step();
        check("t1.edge_k", 32'(evt_pulse), 32'd0);
        step();
        check("t1.edge_k1", 32'(evt_pulse), 32'd0);
        step();
        check_all("t1.rise", 1'b1, 8'd1, 1'b1, 4'd1, 1'b0);
        step();
        check("t1.fall", 32'(evt_pulse), 32'd0);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        check("t1.hs_pend", 32'(pend_count), 32'd0);
        check("t1.hs_valid", 32'(evt_valid), 32'd0);

        // 2: falling toggle counts too
        do_toggle();
        check_all("t2.rise", 1'b1, 8'd2, 1'b1, 4'd1, 1'b0);
        step();
        check("t2.fall", 32'(evt_pulse), 32'd0);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        check("t2.drain", 32'(pend_count), 32'd0);

        // 3: saturation of the pending counter
        for (int i = 0; i < 15; i++) do_toggle();
        check_all("t3.at15", 1'b1, 8'd17, 1'b1, 4'd15, 1'b0);
        do_toggle();
        check_all("t3.drop", 1'b1, 8'd18, 1'b1, 4'd15, 1'b1);

        // 4: edge cases at the ceiling
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("t4.clr", 32'(overflow), 32'd0);
        tog_in = ~tog_in;
        step();
        step();
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        check_all("t4.evt_hs", 1'b1, 8'd19, 1'b1, 4'd15, 1'b0);
        step();
        tog_in = ~tog_in;
        step();
        step();
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check_all("t4.set_wins", 1'b1, 8'd20, 1'b1, 4'd15, 1'b1);
        clr_ovf = 1'b1;
        step();
        clr_ovf = 1'b0;
        check("t4.clr_alone", 32'(overflow), 32'd0);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        check("t4.hs_only", 32'(pend_count), 32'd14);

        // 5: wrap of the event counter with the consumer always ready
        #2 rst_n = 1'b0;
        #1;
        check_all("t5.rst", 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        evt_ready = 1'b1;
        pend_hi   = 1'b0;
        for (int i = 0; i < 255; i++) begin
            tog_in = ~tog_in;
            for (int j = 0; j < 3; j++) begin
                step();
                if (pend_count > 4'd1) pend_hi = 1'b1;
            end
        end
        check("t5.cnt255", 32'(evt_count), 32'd255);
        do_toggle();
        check("t5.wrap", 32'(evt_count), 32'd0);
        step();
        if (pend_count > 4'd1) pend_hi = 1'b1;
        check("t5.pend_le1", 32'(pend_hi), 32'd0);
        check("t5.pend_end", 32'(pend_count), 32'd0);
        check("t5.ovf", 32'(overflow), 32'd0);
        evt_ready = 1'b0;

        // 6: asynchronous reset mid-operation with the line high
        for (int i = 0; i < 5; i++) do_toggle();
        evt_ready = 1'b1;
        step();
        step();
        evt_ready = 1'b0;
        check_all("t6.pre", 1'b0, 8'd5, 1'b1, 4'd3, 1'b0);
        check("t6.tog", 32'(tog_in), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_all("t6.async", 1'b0, 8'd0, 1'b0, 4'd0, 1'b0);
        step();
        rst_n = 1'b1;
        step();
        step();
        check("t6.k1", 32'(evt_pulse), 32'd0);
        step();
        check_all("t6.evt", 1'b1, 8'd1, 1'b1, 4'd1, 1'b0);
        step();
        step();
        step();
        check("t6.once_cnt", 32'(evt_count), 32'd1);
        check("t6.once_pls", 32'(evt_pulse), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
